// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time from
// instruction memory and hands {pc, inst} to decode over valid/ready.
// At most one fetch is outstanding at any time. A flush retargets the PC
// from any state. A response for a request that has been overtaken by a
// flush is swallowed in DROP.
module ysyx_22050019_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory request / response
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  // decode handshake
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_inst,
  // next-PC sources
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        flush_valid,
  input  logic [63:0] flush_pc
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_DROP = 3'd4;

  // No compressed instructions: every PC is word aligned.
  function automatic logic [63:0] f_align(input logic [63:0] addr);
    f_align = {addr[63:2], 2'b00};
  endfunction

  logic [2:0]  r_state;
  logic [63:0] r_pc;
  logic [63:0] r_if_pc;
  logic [31:0] r_if_inst;
  logic        r_if_valid;
  logic        r_req_valid;

  logic [2:0]  w_state_nxt;
  logic [63:0] w_pc_nxt;
  logic        w_latch;
  logic [63:0] w_flush_pc;
  logic [63:0] w_redirect_pc;
  logic [63:0] w_seq_pc;

  assign w_flush_pc    = f_align(flush_pc);
  assign w_redirect_pc = f_align(redirect_pc);
  assign w_seq_pc      = r_pc + 64'd4;

  // Next state / next PC; flush outranks redirect and normal progress.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_latch     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (flush_valid) begin
          w_pc_nxt = w_flush_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      S_REQ: begin
        if (flush_valid) begin
          // an accepted request still carries the old pc, so its reply must be dropped
          w_pc_nxt    = w_flush_pc;
          w_state_nxt = imem_req_ready ? S_DROP : S_REQ;
        end else if (imem_req_ready) begin
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_REQ;
        end
      end
      S_WAIT: begin
        if (flush_valid) begin
          w_pc_nxt    = w_flush_pc;
          w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
        end else if (imem_rsp_valid) begin
          w_latch     = 1'b1;
          w_state_nxt = S_OUT;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_OUT: begin
        if (flush_valid) begin
          // a coincident handshake still delivers, but its redirect is discarded
          w_pc_nxt    = w_flush_pc;
          w_state_nxt = S_REQ;
        end else if (if_ready) begin
          w_pc_nxt    = redirect_valid ? w_redirect_pc : w_seq_pc;
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_OUT;
        end
      end
      S_DROP: begin
        if (flush_valid) begin
          w_pc_nxt = w_flush_pc;
        end else begin
          w_pc_nxt = r_pc;
        end
        if (imem_rsp_valid) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DROP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_pc_nxt    = RESET_PC;
      end
    endcase
  end

  // State, PC and registered handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_if_valid  <= 1'b0;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_if_valid  <= (w_state_nxt == S_OUT);
      r_req_valid <= (w_state_nxt == S_REQ);
    end
  end

  // Capture the fetched word and its PC; held stable while decode stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_pc   <= RESET_PC;
      r_if_inst <= 32'd0;
    end else if (w_latch) begin
      r_if_pc   <= r_pc;
      r_if_inst <= imem_rsp_data;
    end else begin
      r_if_pc   <= r_if_pc;
      r_if_inst <= r_if_inst;
    end
  end

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = f_align(r_pc);
  assign if_valid       = r_if_valid;
  assign if_pc          = r_if_pc;
  assign if_inst        = r_if_inst;

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Directed bench for ysyx_22050019_ifu: inputs change 1 time unit after the
// rising edge and outputs are checked there, well away from the next edge.
module tb_ysyx_22050019_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_inst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        flush_valid;
  logic [63:0] flush_pc;

  int n_cmp;
  int n_bad;

  ysyx_22050019_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_valid    (flush_valid),
    .flush_pc       (flush_pc)
  );

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in REQ with req_ready=1: checks the request, answers one cycle
  // after acceptance and checks the word presented to decode.
  task automatic fetch(input string tag, input logic [63:0] addr, input logic [31:0] data);
    chk({tag, ".req_valid"}, {63'd0, imem_req_valid}, 64'd1);
    chk({tag, ".req_addr"}, imem_req_addr, addr);
    chk({tag, ".if_valid_req"}, {63'd0, if_valid}, 64'd0);
    tick();
    chk({tag, ".wait_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
    chk({tag, ".wait_if_valid"}, {63'd0, if_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    chk({tag, ".if_valid"}, {63'd0, if_valid}, 64'd1);
    chk({tag, ".if_pc"}, if_pc, addr);
    chk({tag, ".if_inst"}, {32'd0, if_inst}, {32'd0, data});
    chk({tag, ".out_req_valid"}, {63'd0, imem_req_valid}, 64'd0);
  endtask

  // Handshake in OUT; leaves the DUT in REQ.
  task automatic consume();
    if_ready = 1'b1;
    tick();
    if_ready = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;
    flush_valid    = 1'b0;
    flush_pc       = 64'd0;

    // ---- 1: reset values and in-order sequential fetch
    tick();
    tick();
    chk("rst.req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("rst.if_valid", {63'd0, if_valid}, 64'd0);
    chk("rst.if_pc", if_pc, 64'h0000_0000_8000_0000);
    chk("rst.if_inst", {32'd0, if_inst}, 64'd0);
    chk("rst.req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
    rst_n = 1'b1;
    #1;
    chk("idle.req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick();
    fetch("seq0", 64'h0000_0000_8000_0000, 32'h0000_0013);
    consume();
    fetch("seq1", 64'h0000_0000_8000_0004, 32'h0010_0093);
    consume();
    fetch("seq2", 64'h0000_0000_8000_0008, 32'h0020_0113);

    // ---- 2/3: backpressure, with a redirect that must be ignored
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp.if_valid", {63'd0, if_valid}, 64'd1);
      chk("bp.if_pc", if_pc, 64'h0000_0000_8000_0008);
      chk("bp.if_inst", {32'd0, if_inst}, 64'h0000_0000_0020_0113);
      chk("bp.req_valid", {63'd0, imem_req_valid}, 64'd0);
    end
    redirect_valid = 1'b0;
    consume();
    fetch("bp_next", 64'h0000_0000_8000_000C, 32'h0030_0193);
    consume();
    fetch("pre_redir", 64'h0000_0000_8000_0010, 32'h0000_006F);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0100;
    consume();
    redirect_valid = 1'b0;
    fetch("redir", 64'h0000_0000_8000_0100, 32'h0040_0213);
    consume();

    // ---- 4: flush while waiting; stale response arrives 3 cycles after accept
    chk("f4.req_addr", imem_req_addr, 64'h0000_0000_8000_0104);
    tick();
    flush_valid = 1'b1;
    flush_pc    = 64'h0000_0000_8000_0200;
    tick();
    flush_valid = 1'b0;
    chk("f4.drop_req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("f4.drop_if_valid", {63'd0, if_valid}, 64'd0);
    tick();
    chk("f4.drop2_if_valid", {63'd0, if_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("f4.stale_if_valid", {63'd0, if_valid}, 64'd0);
    fetch("f4", 64'h0000_0000_8000_0200, 32'h0050_0293);
    consume();

    // ---- 5: flush and redirect on the same handshake; flush in REQ while stalled
    fetch("f5a", 64'h0000_0000_8000_0204, 32'h0060_0313);
    flush_valid    = 1'b1;
    flush_pc       = 64'h0000_0000_8000_0300;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h0000_0000_8000_0400;
    if_ready       = 1'b1;
    tick();
    flush_valid    = 1'b0;
    redirect_valid = 1'b0;
    if_ready       = 1'b0;
    imem_req_ready = 1'b0;
    chk("f5.if_valid", {63'd0, if_valid}, 64'd0);
    chk("f5.req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("f5.req_addr", imem_req_addr, 64'h0000_0000_8000_0300);
    tick();
    chk("f5.stall_addr", imem_req_addr, 64'h0000_0000_8000_0300);
    flush_valid = 1'b1;
    flush_pc    = 64'h0000_0000_8000_0502;
    tick();
    flush_valid = 1'b0;
    chk("f5.retarget_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("f5.retarget_addr", imem_req_addr, 64'h0000_0000_8000_0500);
    imem_req_ready = 1'b1;
    fetch("f5b", 64'h0000_0000_8000_0500, 32'h0070_0393);
    consume();

    // flush on the accepting cycle -> reply must be dropped
    flush_valid = 1'b1;
    flush_pc    = 64'h0000_0000_8000_0600;
    tick();
    flush_valid = 1'b0;
    chk("f5c.drop_req_valid", {63'd0, imem_req_valid}, 64'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hBAD0_BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    chk("f5c.if_valid", {63'd0, if_valid}, 64'd0);

    // ---- 6: wrap-around and asynchronous reset while waiting
    imem_req_ready = 1'b0;
    flush_valid    = 1'b1;
    flush_pc       = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    flush_valid    = 1'b0;
    imem_req_ready = 1'b1;
    fetch("wrap_hi", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0080_0413);
    consume();
    chk("wrap.req_addr", imem_req_addr, 64'd0);
    tick();
    chk("wrap.wait_req_valid", {63'd0, imem_req_valid}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.req_valid", {63'd0, imem_req_valid}, 64'd0);
    chk("arst.if_valid", {63'd0, if_valid}, 64'd0);
    chk("arst.if_pc", if_pc, 64'h0000_0000_8000_0000);
    chk("arst.if_inst", {32'd0, if_inst}, 64'd0);
    chk("arst.req_addr", imem_req_addr, 64'h0000_0000_8000_0000);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst.idle_req_valid", {63'd0, imem_req_valid}, 64'd0);
    tick();
    fetch("restart", 64'h0000_0000_8000_0000, 32'h0090_0493);
    consume();
    chk("restart.next_addr", imem_req_addr, 64'h0000_0000_8000_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
